rc4_sched: RTL

- Control engine for an RC4 cipher built around a 256-byte S-box RAM.
- The RAM has one combinational read port (port 1), one write-only port (port 2) and one combinational read / synchronous write port (port 3). Both write ports are committed together on a single write enable.
- This block drives all RAM address, data and enable lines. It runs S-box initialisation, the key-scheduling algorithm (KSA) and the pseudo-random generation algorithm (PRGA).
- It delivers keystream bytes downstream over a valid/ready handshake.

---
 rtl/rc4_pkg.sv | 19 +
 rtl/rc4_key_mux.sv | 17 +
 rtl/rc4_sched.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/rc4_pkg.sv
// rc4_pkg: shared types and constants for the RC4 S-box sequencer.
// State encoding plus S-box geometry.
package rc4_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        KSA_RD,
        KSA_SW,
        PRGA_RD,
        PRGA_SW,
        PRGA_OUT,
        WAIT
    } state_t;

    localparam int SBOX_SIZE   = 256;
    localparam int INIT_CYCLES = 128;

endpackage

// File: rtl/rc4_key_mux.sv
// rc4_key_mux: selects one byte of the latched key.
// Byte k of the key lives at bits [8k+7:8k].
module rc4_key_mux #(
    parameter int KEY_BYTES = 16,
    parameter int KW        = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1
) (
    input  logic [8*KEY_BYTES-1:0] i_key,
    input  logic [KW-1:0]          i_kidx,
    output logic [7:0]             o_byte
);

    // indexed part-select of the current key byte
    always_comb begin
        o_byte = i_key[8*i_kidx +: 8];
    end

endmodule

// File: rtl/rc4_sched.sv
// rc4_sched: RC4 control engine driving a 3-port S-box RAM.
// Runs INIT, KSA and PRGA and streams keystream bytes out.
module rc4_sched
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         stop,
    input  logic [8*KEY_BYTES-1:0]       key,
    input  logic [$clog2(KEY_BYTES+1)-1:0] key_len,
    output logic                         busy,
    output logic [7:0]                   ks_data,
    output logic                         ks_valid,
    input  logic                         ks_ready,
    output logic [7:0]                   ram_raddr_1,
    input  logic [7:0]                   ram_rdata_1,
    output logic [7:0]                   ram_waddr_2,
    output logic [7:0]                   ram_wdata_2,
    output logic [7:0]                   ram_addr_3,
    output logic [7:0]                   ram_wdata_3,
    input  logic [7:0]                   ram_rdata_3,
    output logic                         ram_wen
);

    localparam int LW = $clog2(KEY_BYTES+1);
    localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    state_t                 r_state;
    state_t                 w_next;
    logic [7:0]             r_i;
    logic [7:0]             r_j;
    logic [7:0]             r_si;
    logic [7:0]             r_t;
    logic [KW-1:0]          r_kidx;
    logic [LW-1:0]          r_len;
    logic [8*KEY_BYTES-1:0] r_key;
    logic [7:0]             r_ks_data;
    logic                   r_ks_valid;
    logic [7:0]             w_kbyte;
    logic [LW-1:0]          w_eff_len;
    logic                   w_kidx_last;
    logic                   w_init_last;
    logic                   w_i_last;
    logic                   w_accept;

    rc4_key_mux #(
        .KEY_BYTES (KEY_BYTES),
        .KW        (KW)
    ) u_key_mux (
        .i_key  (r_key),
        .i_kidx (r_kidx),
        .o_byte (w_kbyte)
    );

    // A zero or oversize length means "use the whole key".
    assign w_eff_len   = ((key_len == '0) || (int'(key_len) > KEY_BYTES))
                         ? LW'(KEY_BYTES) : key_len;
    assign w_kidx_last = (LW'(r_kidx) == (r_len - LW'(1)));
    // During INIT, r_i doubles as the pair counter c.
    assign w_init_last = (r_i[6:0] == 7'(INIT_CYCLES-1));
    assign w_i_last    = (r_i == 8'(SBOX_SIZE-1));
    assign w_accept    = r_ks_valid && ks_ready;

    assign busy     = (r_state != IDLE);
    assign ks_data  = r_ks_data;
    assign ks_valid = r_ks_valid;

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // next-state logic; stop overrides every transition
    always_comb begin
        w_next = r_state;
        if (stop) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:     if (start)       w_next = INIT;
                INIT:     if (w_init_last) w_next = KSA_RD;
                KSA_RD:                    w_next = KSA_SW;
                KSA_SW:   w_next = w_i_last ? PRGA_RD : KSA_RD;
                PRGA_RD:                   w_next = PRGA_SW;
                PRGA_SW:                   w_next = PRGA_OUT;
                PRGA_OUT:                  w_next = WAIT;
                WAIT:     if (w_accept)    w_next = PRGA_RD;
                default:                   w_next = IDLE;
            endcase
        end
    end

    // RAM address/data/enable decode from registered state
    always_comb begin
        ram_raddr_1 = '0;
        ram_waddr_2 = '0;
        ram_wdata_2 = '0;
        ram_addr_3  = '0;
        ram_wdata_3 = '0;
        ram_wen     = 1'b0;
        case (r_state)
            INIT: begin
                ram_waddr_2 = {r_i[6:0], 1'b0};
                ram_wdata_2 = {r_i[6:0], 1'b0};
                ram_addr_3  = {r_i[6:0], 1'b1};
                ram_wdata_3 = {r_i[6:0], 1'b1};
                ram_wen     = 1'b1;
            end
            KSA_RD:   ram_raddr_1 = r_i;
            KSA_SW, PRGA_SW: begin
                ram_addr_3  = r_j;
                ram_waddr_2 = r_i;
                ram_wdata_2 = ram_rdata_3;
                ram_wdata_3 = r_si;
                ram_wen     = 1'b1;
            end
            PRGA_RD:  ram_raddr_1 = r_i + 8'd1;
            PRGA_OUT: ram_raddr_1 = r_t;
            default: ;
        endcase
        // never let an aborted swap reach the RAM
        if (stop) ram_wen = 1'b0;
    end

    // datapath registers: indices, swap temporaries, key and output byte
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_i        <= '0;
            r_j        <= '0;
            r_si       <= '0;
            r_t        <= '0;
            r_kidx     <= '0;
            r_len      <= '0;
            r_key      <= '0;
            r_ks_data  <= '0;
            r_ks_valid <= 1'b0;
        end else if (stop) begin
            r_ks_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_key  <= key;
                        r_len  <= w_eff_len;
                        r_i    <= '0;
                        r_j    <= '0;
                        r_kidx <= '0;
                    end
                end
                INIT: begin
                    r_i <= w_init_last ? 8'd0 : r_i + 8'd1;
                    if (w_init_last) begin
                        r_j    <= '0;
                        r_kidx <= '0;
                    end
                end
                KSA_RD: begin
                    r_si <= ram_rdata_1;
                    r_j  <= r_j + ram_rdata_1 + w_kbyte;
                end
                KSA_SW: begin
                    r_i    <= r_i + 8'd1;
                    r_kidx <= w_kidx_last ? '0 : r_kidx + KW'(1);
                    if (w_i_last) r_j <= '0;
                end
                PRGA_RD: begin
                    r_i  <= r_i + 8'd1;
                    r_si <= ram_rdata_1;
                    r_j  <= r_j + ram_rdata_1;
                end
                PRGA_SW:  r_t <= r_si + ram_rdata_3;
                PRGA_OUT: begin
                    r_ks_data  <= ram_rdata_1;
                    r_ks_valid <= 1'b1;
                end
                WAIT:     if (w_accept) r_ks_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
